// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: sequences a pixel stream into a 3x3 line buffer.
// It tracks the column and row of every accepted pixel and flags when a full
// 3x3 window is formed. The frame is paced by start, abort and the end of the frame.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; pixels are not accepted
// FILL   | accepting rows 0..1; the line buffer is priming
// RUN    | accepting rows 2..IMG_H-1; windows become valid from col 2
// DONE   | one cycle after the last pixel; frame_done pulse
module conv_window_ctrl #(
    parameter int IMG_W = 480,
    parameter int IMG_H = 272,
    parameter int DW    = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          pix_valid,
    input  logic [DW-1:0] pix_data,
    output logic          pix_ready,
    output logic          lb_valid_in,
    output logic [DW-1:0] lb_din,
    output logic [9:0]    col_cnt,
    output logic [9:0]    row_cnt,
    output logic          win_valid,
    output logic          busy,
    output logic          frame_done
);

    localparam logic [9:0] LAST_COL = 10'(IMG_W - 1);
    localparam logic [9:0] LAST_ROW = 10'(IMG_H - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [9:0] r_nxt_col;
    logic [9:0] r_nxt_row;
    logic       w_accept;
    logic       w_last_col;
    logic       w_fill_end;
    logic       w_frame_end;

    assign w_accept    = pix_valid & pix_ready;
    assign w_last_col  = (r_nxt_col == LAST_COL);
    assign w_fill_end  = w_accept & w_last_col & (r_nxt_row == 10'd1);
    assign w_frame_end = w_accept & w_last_col & (r_nxt_row == LAST_ROW);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and state-derived outputs; abort overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        pix_ready   = 1'b0;
        busy        = 1'b0;
        frame_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_FILL;
            end
            S_FILL: begin
                pix_ready = ~abort;
                busy      = 1'b1;
                if (w_fill_end) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                pix_ready = ~abort;
                busy      = 1'b1;
                if (w_frame_end) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                busy        = 1'b1;
                frame_done  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (abort) w_state_nxt = S_IDLE;
    end

    // Position of the next pixel to be accepted. It stalls on bubbles and
    // returns to 0,0 after the last pixel so that it cannot run past the last row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nxt_col <= '0;
            r_nxt_row <= '0;
        end else if (abort || (r_state == S_IDLE && start)) begin
            r_nxt_col <= '0;
            r_nxt_row <= '0;
        end else if (w_accept) begin
            if (w_last_col) begin
                r_nxt_col <= '0;
                r_nxt_row <= (r_nxt_row == LAST_ROW) ? 10'd0 : r_nxt_row + 10'd1;
            end else begin
                r_nxt_col <= r_nxt_col + 10'd1;
            end
        end
    end

    // One-cycle pipeline to the line buffer. Data and indices hold on bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lb_valid_in <= 1'b0;
            lb_din      <= '0;
            col_cnt     <= '0;
            row_cnt     <= '0;
            win_valid   <= 1'b0;
        end else begin
            lb_valid_in <= 1'b0;
            win_valid   <= 1'b0;
            if (abort) begin
                col_cnt <= '0;
                row_cnt <= '0;
            end else if (w_accept) begin
                lb_valid_in <= 1'b1;
                lb_din      <= pix_data;
                col_cnt     <= r_nxt_col;
                row_cnt     <= r_nxt_row;
                win_valid   <= (r_nxt_row >= 10'd2) && (r_nxt_col >= 10'd2);
            end
        end
    end

endmodule

// File: doc/conv_window_ctrl.md
CONV_WINDOW_CTRL -- requirements
Module: conv_window_ctrl

Interface
REQ-001 Parameter IMG_W, default 480, pixels per image row (4..1023).
REQ-002 Parameter IMG_H, default 272, rows per frame (3..1023).
REQ-003 Parameter DW, default 10, pixel data width.
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle pulse; begins a frame when idle.
REQ-007 abort  input  1  synchronous soft clear; returns to idle.
REQ-008 pix_valid  input  1  upstream pixel present.
REQ-009 pix_data  input  DW  upstream pixel value.
REQ-010 pix_ready  output  1  controller accepts pixels this cycle.
REQ-011 lb_valid_in  output  1  drives the 3x3 line-buffer valid_in.
REQ-012 lb_din  output  DW  drives the 3x3 line-buffer din.
REQ-013 col_cnt  output  10  column index of the pixel on lb_din.
REQ-014 row_cnt  output  10  row index of the pixel on lb_din.
REQ-015 win_valid  output  1  full 3x3 window is formed at the line-buffer output.
REQ-016 busy  output  1  frame in progress.
REQ-017 frame_done  output  1  one-cycle pulse after the last pixel of a frame.

Function
REQ-018 FSM states IDLE, FILL, RUN, DONE, binary-encoded; reset state IDLE.
REQ-019 IDLE->FILL on start; start is ignored in FILL, RUN and DONE.
REQ-020 FILL->RUN on acceptance of pixel (row 1, col IMG_W-1).
REQ-021 RUN->DONE on acceptance of pixel (row IMG_H-1, col IMG_W-1); DONE->IDLE unconditionally after one cycle.
REQ-022 pix_ready is 1 in FILL and RUN when abort is 0; otherwise it is 0 (combinational from state and abort).
REQ-023 Accept = pix_valid & pix_ready; no pixel is accepted or dropped without accept.
REQ-024 Latency is one cycle: on accept, next cycle lb_valid_in=1, lb_din=pix_data, and col_cnt/row_cnt = indices of that pixel.
REQ-025 Without accept, lb_valid_in=0, and lb_din, col_cnt and row_cnt hold their values.
REQ-026 Internal next-column counter wraps from IMG_W-1 to 0 and increments the next-row counter; no overflow beyond IMG_H-1.
REQ-027 win_valid registered with lb_valid_in: 1 only when the accepted pixel has row>=2 and col>=2.
REQ-028 Gaps in pix_valid (bubbles) stall counters; window alignment is unaffected.
REQ-029 frame_done=1 exactly during the DONE cycle; busy=1 in FILL, RUN and DONE.
REQ-030 abort in any state: next state IDLE, counters 0, lb_valid_in/win_valid 0; abort wins over a simultaneous accept (that pixel is not accepted).
REQ-031 abort and start in the same cycle in IDLE: abort wins, state stays IDLE.
REQ-032 Back-to-back frames: start in the cycle after DONE (state IDLE) begins a new frame at row 0, col 0.

Reset
REQ-033 On rst_n low, immediately: state IDLE, internal counters 0, lb_valid_in 0, lb_din 0, col_cnt 0, row_cnt 0, win_valid 0, busy 0, frame_done 0.
REQ-034 Reset asserted mid-frame discards the frame; after release the controller waits for a new start.

Verification
REQ-035 IMG_W=8, IMG_H=4, start then pix_valid held 1 -> 32 lb_valid_in pulses, win_valid on 12 of them (rows 2-3, cols 2-7), frame_done one cycle after the 32nd.
REQ-036 Same setup, pix_valid toggled 1/0 every cycle -> identical lb_din/col/row sequence; lb_valid_in 0 on bubble cycles.
REQ-037 abort while row_cnt=2, col_cnt=5 with pix_valid=1 -> pix_ready 0 that cycle, state IDLE, no further lb_valid_in until next start.
REQ-038 rst_n low mid-frame at row 1 -> all outputs 0 asynchronously; start after release -> first output col 0, row 0.
REQ-039 start pulsed during RUN -> no effect on counters; start one cycle after DONE -> second frame completes with correct indices.
REQ-040 IMG_W=480, IMG_H=5, ramp data 0..479 per row -> win_valid first on row 2, col 2; lb_din equals col_cnt on every valid cycle.
